fft_top_div_seq: RTL



---
 rtl/fft_top_div_pkg.sv | 20 ++
 rtl/fft_top_div_step.sv | 19 +
 rtl/fft_top_div_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fft_top_div_pkg.sv
// rtl/fft_top_div_pkg.sv - shared widths, FSM states and saturation bounds for the sequential divider
package fft_top_div_pkg;

    localparam int DEF_DIVIDEND_W = 41;
    localparam int DEF_DIVISOR_W  = 15;
    localparam int DEF_QUOT_W     = 26;

    localparam int CNT_W = $clog2(DEF_DIVIDEND_W);

    localparam logic [DEF_QUOT_W-1:0] QUOT_MAX = {1'b0, {(DEF_QUOT_W-1){1'b1}}};
    localparam logic [DEF_QUOT_W-1:0] QUOT_MIN = {1'b1, {(DEF_QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/fft_top_div_step.sv
// rtl/fft_top_div_step.sv - one combinational radix-2 restoring division iteration
module fft_top_div_step #(
    parameter int W = 15
) (
    input  logic [W-1:0] pr_in,
    input  logic         bit_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] pr_out,
    output logic         q_bit
);
    logic [W:0] shifted;

    assign shifted = {pr_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, dvs});

    // The true difference is below dvs whenever it is taken, so W bits suffice
    assign pr_out = q_bit ? (shifted[W-1:0] - dvs) : shifted[W-1:0];

endmodule

// File: rtl/fft_top_div_seq.sv
// rtl/fft_top_div_seq.sv - sequential restoring signed divider; FFT_DIV_ROUND_EN selects round-to-nearest quotient
module fft_top_div_seq
    import fft_top_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  div_by_zero,
    output logic                  ovf
);
    localparam int MW = DIVIDEND_W + 1;
    localparam logic [MW-1:0] MAG_POS = MW'(QUOT_MAX);
    localparam logic [MW-1:0] MAG_NEG = MW'(QUOT_MIN);

    div_state_t state, state_d;

    logic [CNT_W-1:0]     cnt;
    logic [MW-1:0]        dvd_mag, q_mag, q_adj;
    logic [DIVISOR_W-1:0] dvs_mag, pr, step_pr;
    logic                 step_q, neg_q, neg_r, dz;

    logic [MW-1:0]        a_ext, a_mag;
    logic [DIVISOR_W-1:0] b_mag;
    logic [QUOT_W-1:0]    quot_d;
    logic [DIVISOR_W-1:0] rem_d;
    logic                 ovf_d;

    // One extra magnitude bit so that the most negative dividend has a representable magnitude
    always_comb begin
        a_ext = {din0[DIVIDEND_W-1], din0};
        a_mag = a_ext[MW-1] ? (~a_ext + MW'(1)) : a_ext;
        b_mag = din1[DIVISOR_W-1] ? (~din1 + DIVISOR_W'(1)) : din1;
    end

    fft_top_div_step #(.W(DIVISOR_W)) u_step (
        .pr_in  (pr),
        .bit_in (dvd_mag[cnt]),
        .dvs    (dvs_mag),
        .pr_out (step_pr),
        .q_bit  (step_q)
    );

    always_comb begin
`ifdef FFT_DIV_ROUND_EN
        q_adj = ({pr, 1'b0} >= {1'b0, dvs_mag}) ? (q_mag + MW'(1)) : q_mag;
`else
        q_adj = q_mag;
`endif
        quot_d = neg_q ? (~q_adj[QUOT_W-1:0] + QUOT_W'(1)) : q_adj[QUOT_W-1:0];
        rem_d  = neg_r ? (~pr + DIVISOR_W'(1)) : pr;
        ovf_d  = 1'b0;
        if (dz) begin
            quot_d = neg_r ? QUOT_W'(QUOT_MIN) : QUOT_W'(QUOT_MAX);
            rem_d  = '0;
            ovf_d  = 1'b1;
        end else if (!neg_q && (q_adj > MAG_POS)) begin
            quot_d = QUOT_W'(QUOT_MAX);
            ovf_d  = 1'b1;
        end else if (neg_q && (q_adj > MAG_NEG)) begin
            quot_d = QUOT_W'(QUOT_MIN);
            ovf_d  = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (ce && in_valid) state_d = (din1 == '0) ? FIX : CALC;
            CALC: if (ce && (cnt == '0)) state_d = FIX;
            FIX:  if (ce) state_d = DONE;
            DONE: if (ce && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            dvd_mag     <= '0;
            dvs_mag     <= '0;
            pr          <= '0;
            q_mag       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            out_valid   <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_mag <= a_mag;
                        dvs_mag <= b_mag;
                        neg_q   <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                        neg_r   <= din0[DIVIDEND_W-1];
                        dz      <= (din1 == '0);
                        cnt     <= CNT_W'(DIVIDEND_W - 1);
                        pr      <= '0;
                        q_mag   <= '0;
                    end
                end
                CALC: begin
                    pr    <= step_pr;
                    q_mag <= {q_mag[MW-2:0], step_q};
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quot        <= quot_d;
                    rem         <= rem_d;
                    div_by_zero <= dz;
                    ovf         <= ovf_d;
                    out_valid   <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
